// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO. No types live here: the FIFO is
// self-contained and its thresholds are plain parameters.
package fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer: async reset, sync clear, increment on request.
// The MSB is the wrap bit used by the owner to tell full from empty.
module fifo_ptr #(
   parameter int PTR_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 inc,
   output logic [PTR_WIDTH-1:0] ptr
);

   logic [PTR_WIDTH-1:0] r_ptr;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (flush) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign ptr = r_ptr;

endmodule : fifo_ptr

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int PTR_WIDTH = $clog2(DEPTH) + 1,
   parameter int AFULL     = DEPTH - 1,
   parameter int AEMPTY    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 wen,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 ren,
   output logic [WIDTH-1:0]     rdata,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [PTR_WIDTH-1:0] count,
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 clr_err
);

   localparam int AW = PTR_WIDTH - 1;

   logic [PTR_WIDTH-1:0] w_wr_ptr;
   logic [PTR_WIDTH-1:0] w_rd_ptr;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr_en;
   logic                 w_rd_en;
   logic                 w_wr_rej;
   logic                 w_rd_rej;
   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic                 r_overflow;
   logic                 r_underflow;

   assign w_full  = (w_wr_ptr[AW] != w_rd_ptr[AW]) && (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);
   assign w_empty = (w_wr_ptr == w_rd_ptr);

   // Full blocks writes and empty blocks reads even when the opposite side
   // frees or fills a slot in the same cycle: there is no bypass path.
   assign w_wr_en  = wen & ~w_full  & ~flush;
   assign w_rd_en  = ren & ~w_empty & ~flush;
   assign w_wr_rej = wen &  w_full  & ~flush;
   assign w_rd_rej = ren &  w_empty & ~flush;

   fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (w_wr_en),
      .ptr   (w_wr_ptr)
   );

   fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (w_rd_en),
      .ptr   (w_rd_ptr)
   );

   // NOTE: storage has no reset; empty/count gate its validity, and leaving
   // it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Clear first, then set, so a new error in a clr_err cycle still sticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end
         if (w_wr_rej) begin
            r_overflow <= 1'b1;
         end
         if (w_rd_rej) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign rdata        = r_mem[w_rd_ptr[AW-1:0]];
   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = w_wr_ptr - w_rd_ptr;
   assign almost_full  = (count >= PTR_WIDTH'(AFULL));
   assign almost_empty = (count <= PTR_WIDTH'(AEMPTY));
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_sync_fifo;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int PW     = $clog2(DEPTH) + 1;
   localparam int AFULL  = DEPTH - 1;
   localparam int AEMPTY = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             wen = 1'b0;
   logic [WIDTH-1:0] wdata = '0;
   logic             ren = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] rdata;
   logic             full, empty, almost_full, almost_empty, overflow, underflow;
   logic [PW-1:0]    count;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   sync_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AFULL(AFULL), .AEMPTY(AEMPTY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wen          (wen),
      .wdata        (wdata),
      .ren          (ren),
      .rdata        (rdata),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares every output against the model's view of the FIFO.
   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ":count"}, 32'(count), 32'(n));
      check({tag, ":empty"}, 32'(empty), 32'(n == 0));
      check({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      check({tag, ":afull"}, 32'(almost_full), 32'(n >= AFULL));
      check({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AEMPTY));
      check({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ":unf"}, 32'(underflow), 32'(m_unf));
      if (n > 0) check({tag, ":rdata"}, 32'(rdata), 32'(q[0]));
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d,
                       input logic r, input logic f, input logic c);
      bit was_full, was_empty;
      wen = w; wdata = d; ren = r; flush = f; clr_err = c;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      @(posedge clk);
      #1;
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (f) begin
         q.delete();
      end else begin
         if (w && was_full)  m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
         if (r && !was_empty) void'(q.pop_front());
         if (w && !was_full)  q.push_back(d);
      end
      wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] fill [4];
      fill[0] = 8'hA1; fill[1] = 8'hB2; fill[2] = 8'hC3; fill[3] = 8'hD4;

      #3;
      check_all("reset");
      #4 rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, fill[i], 1'b0, 1'b0, 1'b0);
      step("overflow_write", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      step("full_wr_rd", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step("underflow_read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step("empty_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      step("clr_err", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step("to_two", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3 * DEPTH; i++)
         step("stream", 1'b1, WIDTH'($urandom), 1'b1, 1'b0, 1'b0);

      step("to_three", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      step("err_set", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      step("err_set", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      step("clr_vs_set", 1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
      step("drop_one", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step("flush", 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      step("after_flush", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++)
         step("random", 1'($urandom_range(0, 1)), WIDTH'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 15) == 0));

      step("pre_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step("pre_rst_fill", 1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
      step("pre_rst_err", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: storage, read and write pointers, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. It is the general-purpose buffer between NPU datapath stages, such as weight/activation staging ahead of the PE array. It replaces standalone pointer blocks with one self-contained controller.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `PTR_WIDTH`, default `$clog2(DEPTH)+1`: pointer width; MSB is the wrap bit.
- `AFULL`, default `DEPTH-1`: `almost_full` asserts when `count >= AFULL`; legal range 1..DEPTH.
- `AEMPTY`, default 1: `almost_empty` asserts when `count <= AEMPTY`; legal range 0..DEPTH-1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous clear of the contents.
- `wen`  in  1  write request.
- `wdata`  in  WIDTH  write data.
- `ren`  in  1  read (pop) request.
- `rdata`  out  WIDTH  head-of-queue data, first-word-fall-through.
- `full`  out  1  DEPTH entries held.
- `empty`  out  1  zero entries held.
- `almost_full`  out  1  `count >= AFULL`.
- `almost_empty`  out  1  `count <= AEMPTY`.
- `count`  out  PTR_WIDTH  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.
- `clr_err`  in  1  synchronous clear of `overflow` and `underflow`.

## Operation
- Write accepted when `wen & ~full & ~flush`: `mem[w_ptr[PTR_WIDTH-2:0]] <= wdata`, and `w_ptr` increments.
- Read accepted when `ren & ~empty & ~flush`: `r_ptr` increments. `rdata` is always `mem[r_ptr[PTR_WIDTH-2:0]]` and is valid only while `~empty`.
- Pointers wrap modulo 2^PTR_WIDTH.
  - `full` = wrap bits differ and the low bits are equal.
  - `empty` = pointers are equal.
- `count` = `w_ptr - r_ptr`, computed modulo 2^PTR_WIDTH. It never exceeds DEPTH.
- A simultaneous write and read on a non-full, non-empty FIFO are both accepted, and `count` is unchanged.
- When full, a write is rejected even if a read is accepted in the same cycle (no bypass).
- When empty, a read is rejected even if a write is accepted in the same cycle (no bypass).
- Rejected write (`wen & full & ~flush`): memory and pointers are untouched, and `overflow` sets.
- Rejected read (`ren & empty & ~flush`): pointers are untouched, and `underflow` sets.
- `flush`:
  - Both pointers go to 0 on the next edge.
  - `flush` overrides `wen` and `ren`; no overflow or underflow is recorded in a flush cycle.
  - Memory contents and error flags are unaffected.
- `clr_err`:
  - Clears both error flags on the next edge.
  - If a new error occurs in the same cycle, setting wins.
- Memory is not reset. `rdata` is don't-care while `empty`.

## Timing
- Reset values, asynchronous on `rst` rise:
  - `w_ptr` = 0, `r_ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `almost_empty` = 1, `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- All status outputs are combinational from the registered pointers and error registers. They reflect an accepted operation one cycle after it is presented, i.e. after the edge.
- Write-to-read latency: data written at edge N appears on `rdata` (with `empty` = 0) after edge N, so it is readable in cycle N+1.
- `rdata` changes only after an edge that accepts a read, or after an edge that writes into an empty FIFO.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Package `fifo_pkg` holds no types. The FIFO is self-contained; the thresholds are parameters.
- Sub-module `fifo_ptr`:
  - Ports: `clk`, `rst`, `flush`, `inc`, `ptr`.
  - A parametrised PTR_WIDTH-bit wrap pointer with async reset and sync clear.
  - Instantiated twice, once for reads and once for writes.
- The top level holds the storage array, the full/empty compare, the count subtraction, the thresholds, and the error flags.

## Test plan
- Reset, then write 0xA1, 0xB2, 0xC3, 0xD4 (DEPTH = 4): `count` steps 1→4; `full` = 1 after the 4th edge; `almost_full` = 1 from count 3; `rdata` = 0xA1 after the first edge.
- Full, then a 5th write of 0xEE: `count` stays 4; `overflow` = 1 and stays set; after reading four entries the sequence is 0xA1, 0xB2, 0xC3, 0xD4 (0xEE never appears); then `empty` = 1.
- Read while empty: `underflow` = 1 and pointers unchanged. Then `clr_err` with no new errors: both flags = 0 after one edge.
- Simultaneous write and read over 3·DEPTH cycles at `count` = 2: `count` stays 2; data order is preserved across pointer wrap-around (wrap bit toggled at least twice).
- Filled to 3 entries, then `flush` with `wen = ren = 1`: after one edge `count` = 0, `empty` = 1, `overflow` and `underflow` unchanged.
- Assert `rst` asynchronously between edges with `count` = 3: `empty` = 1 and `count` = 0 immediately, before the next edge.
